// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: CDB scheduler state encoding and the grant record.
package expipe_pkg;

  localparam int MAX_EU_N  = 5;
  localparam int CDB_IDX_W = $clog2(MAX_EU_N);

  typedef enum logic {
    S_OPEN   = 1'b0,
    S_LOCKED = 1'b1
  } cdb_sched_state_t;

  typedef struct packed {
    logic                 is_max;
    logic [CDB_IDX_W-1:0] idx;
  } cdb_grant_t;

endpackage

// File: rtl/rr_prio_pick.sv
// Cyclic first-set search: first asserted req_i bit at or after start_i, wrapping.
module rr_prio_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [N-1:0] rot;
  logic [W-1:0] off;

  // Rotate so the start position lands on bit 0, then the lowest set bit wins.
  always_comb begin
    // NOTE: every combinationally assigned variable gets a default first so no latch is inferred.
    rot     = '0;
    off     = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[(i + int'(start_i)) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off     = W'(i);
        found_o = 1'b1;
      end
    end
  end

  assign idx_o = W'((int'(off) + int'(start_i)) % N);

endmodule

// File: rtl/cdb_rr_scheduler.sv
// CDB writeback scheduler: max-priority unit first, round-robin among ordinary units,
// starvation-bounded, with the grant locked while the ROB stalls.
module cdb_rr_scheduler
  import expipe_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int IDX_W        = $clog2(N_REQ + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             max_prio_valid_i,
  output logic             max_prio_ready_o,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] ready_o,
  input  logic             rob_ready_i,
  output logic             rob_valid_o,
  output logic             served_max_prio_o,
  output logic [IDX_W-1:0] served_o,
  output logic             starve_yield_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  if (IDX_W > CDB_IDX_W || STARVE_LIMIT < 1) begin : g_param_check
    $error("cdb_rr_scheduler: unsupported N_REQ or STARVE_LIMIT");
  end

  cdb_sched_state_t state_q;
  cdb_grant_t       lock_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic             force_yield;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_found;
  logic             gnt_valid, gnt_is_max;
  logic [IDX_W-1:0] gnt_idx;
  logic [PTR_W-1:0] gnt_unit;
  logic             hs_max, hs_rr, held_valid;

  rr_prio_pick #(.N(N_REQ)) u_pick (
    .req_i   (valid_i),
    .start_i (ptr_q),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  assign force_yield = (starve_cnt_q == LIMIT_C) && (|valid_i);

  always_comb begin
    gnt_valid  = 1'b0;
    gnt_is_max = 1'b0;
    gnt_idx    = '0;
    if (state_q == S_LOCKED) begin
      gnt_valid  = 1'b1;
      gnt_is_max = lock_q.is_max;
      gnt_idx    = IDX_W'(lock_q.idx);
    end else if (max_prio_valid_i && !force_yield) begin
      gnt_valid  = 1'b1;
      gnt_is_max = 1'b1;
    end else if (rr_found) begin
      gnt_valid  = 1'b1;
      gnt_idx    = IDX_W'(rr_idx) + IDX_W'(1);
    end
  end

  assign gnt_unit = PTR_W'(gnt_idx - IDX_W'(1));
  assign hs_max   = gnt_valid && gnt_is_max && rob_ready_i;
  assign hs_rr    = gnt_valid && !gnt_is_max && rob_ready_i;

  assign rob_valid_o       = gnt_valid;
  assign served_max_prio_o = gnt_valid && gnt_is_max;
  assign served_o          = gnt_idx;
  assign max_prio_ready_o  = hs_max;
  assign starve_yield_o    = gnt_valid && !gnt_is_max && force_yield;

  always_comb begin
    ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready_o[i] = hs_rr && (gnt_idx == IDX_W'(i + 1));
    end
  end

  always_comb begin
    ptr_d        = ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (hs_rr) begin
      ptr_d        = PTR_W'((int'(gnt_unit) + 1) % N_REQ);
      starve_cnt_d = '0;
    end else if (!(|valid_i)) begin
      starve_cnt_d = '0;
    end else if (hs_max && starve_cnt_q != LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_i) begin
      state_q      <= S_OPEN;
      lock_q       <= '0;
      ptr_q        <= '0;
      starve_cnt_q <= '0;
    end else if (flush_i) begin
      state_q      <= S_OPEN;
      lock_q       <= '0;
      ptr_q        <= '0;
      starve_cnt_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      starve_cnt_q <= starve_cnt_d;
      unique case (state_q)
        S_OPEN: begin
          if (gnt_valid && !rob_ready_i) begin
            state_q       <= S_LOCKED;
            lock_q.is_max <= gnt_is_max;
            lock_q.idx    <= CDB_IDX_W'(gnt_idx);
          end
        end
        S_LOCKED: begin
          if (rob_ready_i) state_q <= S_OPEN;
        end
        default: state_q <= S_OPEN;
      endcase
    end
  end

  // A locked requester must keep its result valid until it is taken.
  assign held_valid = gnt_is_max ? max_prio_valid_i : valid_i[gnt_unit];

  a_lock_held : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state_q == S_LOCKED && !flush_i) |-> held_valid);

endmodule

// File: doc/cdb_rr_scheduler.md
Name: cdb_rr_scheduler

Overview:
- Schedules writeback onto the single common data bus (CDB) between one maximum-priority unit and N_REQ ordinary execution units.
- Fairness among ordinary units is round-robin, with a rotating pointer.
- A starvation counter bounds how long the maximum-priority unit may monopolise the bus.
- A grant lock keeps the selected source stable while the ROB stalls.
- Sits between the EU result ports and the CDB mux/ROB; drives the CDB mux select.

Parameters:
- N_REQ, 4: number of ordinary requesters (MAX_EU_N-1).
- STARVE_LIMIT, 8: consecutive max-priority transfers allowed while any ordinary request is pending; must be >= 1.
- IDX_W, $clog2(N_REQ+1): width of the served index (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush.
- max_prio_valid_i  in  1  max-priority unit has a result.
- max_prio_ready_o  out  1  max-priority result transferred this cycle.
- valid_i  in  N_REQ  ordinary unit results pending.
- ready_o  out  N_REQ  one-hot; unit i's result transferred this cycle.
- rob_ready_i  in  1  ROB/CDB accepts this cycle.
- rob_valid_o  out  1  a result is presented on the CDB.
- served_max_prio_o  out  1  CDB mux selects the max-priority unit.
- served_o  out  IDX_W  CDB mux select: 0 = max-priority, i+1 = ordinary unit i.
- starve_yield_o  out  1  debug: current grant is a forced yield.

Behaviour:
- State S_OPEN, entered on reset:
  - Grant is computed combinationally from the current inputs.
  - Max-priority wins unless force_yield is active.
  - Otherwise the first asserted valid_i at or after ptr_q (cyclic search) wins.
- force_yield = (starve_cnt_q == STARVE_LIMIT) & |valid_i.
  - When active, an ordinary unit is granted even if max_prio_valid_i = 1.
- Outputs in S_OPEN and S_LOCKED:
  - rob_valid_o = 1 when a grant exists.
  - served_max_prio_o and served_o reflect the grant.
  - served_o = 0 when there is no grant.
- Ready signals:
  - max_prio_ready_o = rob_ready_i & grant_is_max.
  - ready_o[i] = rob_ready_i & grant_is_rr & (grant_idx == i).
- A handshake is rob_valid_o & rob_ready_i. There is zero-cycle latency from request to ready.
- S_OPEN -> S_LOCKED when rob_valid_o & !rob_ready_i.
  - The grant (is_max, idx) is stored in lock registers.
- S_LOCKED:
  - The grant is taken from the lock registers only; new or higher-priority arrivals are ignored.
  - Exit to S_OPEN on handshake.
  - The requester must hold valid while locked. If it drops valid, the violation is flagged by an assertion only; the grant is still held.
- On ordinary handshake of unit i: ptr_q <= (i+1) mod N_REQ, wrapping at N_REQ-1 -> 0.
  - ptr_q is unchanged on max-priority handshakes.
- starve_cnt_q, width $clog2(STARVE_LIMIT+1), saturating:
  - +1 on a max-priority handshake while |valid_i.
  - Cleared on any ordinary handshake.
  - Cleared in any cycle with valid_i == 0.
  - Held otherwise.
- Flush:
  - Next state S_OPEN.
  - Lock registers, starve_cnt_q and ptr_q cleared.
  - Combinational outputs in the flush cycle are still driven but are ignored by consumers.
  - Flush has priority over handshake updates.
- Reset values:
  - State S_OPEN; ptr_q = 0; starve_cnt_q = 0; lock registers = 0.
  - With all inputs low, every output is 0.
- No request at all: rob_valid_o = 0, all readies 0, no state change except the counter clear.

Decomposition:
- Add to expipe_pkg:
  - cdb_sched_state_t enum {S_OPEN, S_LOCKED}.
  - Typedef cdb_grant_t {logic is_max; logic [IDX_W-1:0] idx}.
- Sub-module rr_prio_pick (N parameter):
  - Inputs: request vector and start pointer.
  - Outputs: winning index and found flag.
  - Implemented by rotate, prio_enc_inv, un-rotate.
  - Reusable by other schedulers.

Test Plan:
- Reset, then valid_i = 4'b1010 with rob_ready_i = 1 held -> ready_o = 0010 (served_o = 2), then 1000 (served_o = 4), then 0010; ptr_q wraps to 0 after unit 3.
- max_prio_valid_i = 1 with valid_i = 0001, STARVE_LIMIT = 8, ROB always ready:
  - Expected: 8 max-priority transfers, then one cycle with ready_o = 0001, starve_yield_o = 1, max_prio_ready_o = 0.
  - Afterwards: counter back to 0 and max-priority resumes.
- Stall: valid_i = 0100, rob_ready_i = 0 for 3 cycles, max_prio_valid_i rises in cycle 2:
  - Expected: served_o stays 3 and served_max_prio_o stays 0.
  - When rob_ready_i = 1: ready_o = 0100, then the next cycle grants max-priority.
- Simultaneous valid_i = 1111 and max_prio_valid_i = 1, ROB ready -> max_prio_ready_o = 1, ready_o = 0, ptr_q unchanged.
- flush_i during S_LOCKED with starve_cnt_q = 5, ptr_q = 2 -> next cycle: S_OPEN, counter 0, ptr 0; grant follows the new inputs.
- Asynchronous reset asserted mid-lock -> all state cleared immediately; with inputs low, all outputs 0.
